mc_datapath_seq: RTL and testbench
==================================

# mc_datapath_seq

Multi-cycle sequencing core for the RV32 datapath. It replaces single-cycle, negedge-writeback operation with a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction memory and data memory are reached through wait-state-tolerant request/valid handshakes, and the ecall stall is built into the state machine. Decoder, controller, register file and ALU stay external and combinational. This block holds PC, IR, operand, ALU-out and MDR registers and drives register-file writeback.

## Interface
Parameters:
- XLEN, 32, datapath width
- PC_RESET, 32'h0000_0000, PC value after reset
- DADDR_W, 14, data-memory address bits taken from the ALU result

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  equals pc
- imem_valid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DADDR_W  alu_q[DADDR_W-1:0]
- dmem_wdata  out  XLEN  b_q
- dmem_valid  in  1  load data valid / store accepted
- dmem_rdata  in  XLEN  load data
- instr  out  32  ir_q, to decoder
- mem_read, mem_write, reg_write, mem_to_reg, link, ecall  in  1 each  controller outputs; link = jal|jalr
- rdata1, rdata2  in  XLEN  register-file read data
- a_q, b_q, pc  out  XLEN  ALU operands and current PC
- alu_result, jump_target  in  XLEN  ALU outputs
- jump_flag  in  1  branch taken, or jal/jalr
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_wdata  out  XLEN  writeback data
- io_data  in  XLEN  switch input, zero-extended by the parent
- io_finish  in  1  ecall release (level)
- ecall_busy  out  1  high while in ECALL
- state  out  3  debug encoding
- retire_cnt  out  XLEN  see Configuration

## Operation
- FETCH:
  - imem_req=1 until imem_valid.
  - On imem_valid: ir_q<=imem_rdata, go to DECODE.
- DECODE:
  - a_q<=rdata1, b_q<=rdata2.
  - If ecall, go to ECALL; otherwise go to EXEC.
- EXEC:
  - alu_q<=alu_result.
  - npc_q<=jump_flag ? jump_target : pc+4.
  - If mem_read|mem_write, go to MEM.
  - Else if reg_write, go to WB.
  - Else retire.
- MEM:
  - dmem_req=1, dmem_we=mem_write; held until dmem_valid.
  - Load: mdr_q<=dmem_rdata, go to WB.
  - Store: retire.
- WB:
  - rf_we=1.
  - rf_wdata = mem_to_reg ? mdr_q : link ? pc+4 : alu_q.
  - Retire.
- ECALL:
  - ecall_busy=1; wait while io_finish=0.
  - When io_finish=1: if reg_write, rf_we=1 and rf_wdata=io_data.
  - pc<=pc+4, go to FETCH.
- Retire: pc<=npc_q, go to FETCH.
- pc+4 and address arithmetic are modulo 2^XLEN.
- Writes to x0 are not filtered; the register file discards them.
- imem_valid/dmem_valid arriving outside the matching wait state are ignored.

## Timing
- Reset, while high and on the following cycle:
  - state=FETCH, pc=PC_RESET, ir_q=32'h0000_0013 (nop).
  - a_q=b_q=alu_q=mdr_q=npc_q=0, retire_cnt=0.
  - imem_req, dmem_req, rf_we, ecall_busy all 0 while reset is high.
  - imem_req=1 from the first cycle after reset deassertion.
- Handshake outputs are combinational from state and stay stable until valid.
- Zero-wait memory: valid may be high in the first cycle of req.
- Minimum cycles with zero-wait memories:
  - branch/jump without link, store-free ALU op without rd: 3
  - ALU op / jal / store: 4
  - load: 5
  - ecall: 3 + wait
- Each wait cycle adds one cycle.
- Reset mid-transaction abandons the request. Memories share the same reset.
- io_finish already high on DECODE exit releases ECALL after exactly one cycle.

## Configuration
- DP_RETIRE_CNT_EN defined:
  - retire_cnt increments by 1 on every retire and every ECALL exit.
  - It wraps at 2^XLEN and clears on reset.
- DP_RETIRE_CNT_EN undefined: retire_cnt is tied to 0 and no counter is synthesised.

## Structure
- parameters.v holds:
  - state encodings DP_S_FETCH=0, DP_S_DECODE=1, DP_S_EXEC=2, DP_S_MEM=3, DP_S_WB=4, DP_S_ECALL=5
  - the DP_NOP constant
  - the default XLEN and DADDR_W
- One sub-module, mc_wb_select: combinational writeback mux over mdr_q, pc+4, alu_q and io_data.

## Test plan
- Reset then addi x1,x0,5 (zero-wait) -> imem_req at cycle 1; rf_we pulse in cycle 4 with rf_wdata=5; pc=4.
- lw with dmem_valid delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr stable; rf_wdata=dmem_rdata; 8 cycles total.
- Taken beq, jump_target=0x40 -> no rf_we, no dmem_req; next imem_addr=0x40 after 3 cycles.
- jal at pc=0x10 -> rf_wdata=0x14, next pc=jump_target.
- ecall with reg_write=1, io_finish held low 10 cycles then high, io_data=0xA5 -> ecall_busy for 11 cycles, rf_wdata=0xA5, pc+4; with DP_RETIRE_CNT_EN, retire_cnt+1.
- Reset asserted during MEM wait, then late dmem_valid -> FETCH at PC_RESET; late valid ignored, no rf_we.

Source files
------------

// File: rtl/mc_datapath_seq_pkg.sv
// Shared types and constants for the multi-cycle RV32 sequencing core:
// state encodings, the nop instruction and default widths.
package mc_datapath_seq_pkg;

    localparam int DP_XLEN    = 32;
    localparam int DP_DADDR_W = 14;

    localparam logic [31:0] DP_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        DP_S_FETCH  = 3'd0,
        DP_S_DECODE = 3'd1,
        DP_S_EXEC   = 3'd2,
        DP_S_MEM    = 3'd3,
        DP_S_WB     = 3'd4,
        DP_S_ECALL  = 3'd5
    } dp_state_e;

endpackage

// File: rtl/mc_datapath_seq_wb_select.sv
// Register-file writeback mux: io data during an ecall exit,
// otherwise load data, link address or the latched ALU result.
module mc_wb_select
    import mc_datapath_seq_pkg::*;
#(
    parameter int XLEN = DP_XLEN
) (
    input  logic [XLEN-1:0] mdr_q,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] alu_q,
    input  logic [XLEN-1:0] io_data,
    input  logic            io_sel,
    input  logic            mem_to_reg,
    input  logic            link,
    output logic [XLEN-1:0] wdata
);

    // priority select of the writeback source
    always_comb begin
        wdata = alu_q;
        if (io_sel) begin
            wdata = io_data;
        end else if (mem_to_reg) begin
            wdata = mdr_q;
        end else if (link) begin
            wdata = pc_plus4;
        end
    end

endmodule

// File: rtl/mc_datapath_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/ECALL sequencer for the RV32 datapath.
// Optional retire counter enabled by defining DP_RETIRE_CNT_EN.
module mc_datapath_seq
    import mc_datapath_seq_pkg::*;
#(
    parameter int              XLEN     = DP_XLEN,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int              DADDR_W  = DP_DADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_valid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [31:0]        instr,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic               mem_to_reg,
    input  logic               link,
    input  logic               ecall,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    output logic [XLEN-1:0]    a_q,
    output logic [XLEN-1:0]    b_q,
    output logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    jump_target,
    input  logic               jump_flag,
    output logic               rf_we,
    output logic [XLEN-1:0]    rf_wdata,
    input  logic [XLEN-1:0]    io_data,
    input  logic               io_finish,
    output logic               ecall_busy,
    output logic [2:0]         state,
    output logic [XLEN-1:0]    retire_cnt
);

    dp_state_e       state_q;
    dp_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mdr_q;
    logic [XLEN-1:0] npc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] npc_exec;
    logic [XLEN-1:0] pc_next;
    logic            retire;
    logic            wb_io;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign npc_exec   = jump_flag ? jump_target : pc_plus4;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instr      = ir_q;
    assign dmem_addr  = alu_q[DADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign state      = state_q;

    // ecall exits skip the EXEC target; EXEC retires use the live target
    always_comb begin
        pc_next = npc_q;
        if (state_q == DP_S_ECALL) begin
            pc_next = pc_plus4;
        end else if (state_q == DP_S_EXEC) begin
            pc_next = npc_exec;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DP_S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake/writeback strobes, all gated off in reset
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        ecall_busy = 1'b0;
        retire     = 1'b0;
        wb_io      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                DP_S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_valid) begin
                        state_d = DP_S_DECODE;
                    end
                end
                DP_S_DECODE: begin
                    state_d = ecall ? DP_S_ECALL : DP_S_EXEC;
                end
                DP_S_EXEC: begin
                    if (mem_read || mem_write) begin
                        state_d = DP_S_MEM;
                    end else if (reg_write) begin
                        state_d = DP_S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = DP_S_FETCH;
                    end
                end
                DP_S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_write;
                    if (dmem_valid) begin
                        if (mem_write) begin
                            retire  = 1'b1;
                            state_d = DP_S_FETCH;
                        end else begin
                            state_d = DP_S_WB;
                        end
                    end
                end
                DP_S_WB: begin
                    rf_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = DP_S_FETCH;
                end
                DP_S_ECALL: begin
                    ecall_busy = 1'b1;
                    wb_io      = 1'b1;
                    if (io_finish) begin
                        rf_we   = reg_write;
                        retire  = 1'b1;
                        state_d = DP_S_FETCH;
                    end
                end
                default: begin
                    state_d = DP_S_FETCH;
                end
            endcase
        end
    end

    // datapath registers, each loaded in the state that owns it
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= DP_NOP;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            npc_q <= '0;
        end else begin
            if (state_q == DP_S_FETCH && imem_valid) begin
                ir_q <= imem_rdata;
            end
            if (state_q == DP_S_DECODE) begin
                a_q <= rdata1;
                b_q <= rdata2;
            end
            if (state_q == DP_S_EXEC) begin
                alu_q <= alu_result;
                npc_q <= npc_exec;
            end
            if (state_q == DP_S_MEM && dmem_valid && !mem_write) begin
                mdr_q <= dmem_rdata;
            end
            if (retire) begin
                pc_q <= pc_next;
            end
        end
    end

`ifdef DP_RETIRE_CNT_EN
    logic [XLEN-1:0] cnt_q;

    // count retired instructions, including ecall exits
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

    mc_wb_select #(
        .XLEN(XLEN)
    ) u_wb_select (
        .mdr_q     (mdr_q),
        .pc_plus4  (pc_plus4),
        .alu_q     (alu_q),
        .io_data   (io_data),
        .io_sel    (wb_io),
        .mem_to_reg(mem_to_reg),
        .link      (link),
        .wdata     (rf_wdata)
    );

endmodule

// File: tb/tb_mc_datapath_seq.sv
// Scoreboard bench for mc_datapath_seq: directed instructions with
// memory/io responders; a monitor checks fetches, data accesses, writebacks.
module tb_mc_datapath_seq;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_ALU   = 7'b0010000;
    localparam logic [6:0] C_LW    = 7'b1011000;
    localparam logic [6:0] C_SW    = 7'b0100000;
    localparam logic [6:0] C_BR    = 7'b0000001;
    localparam logic [6:0] C_JAL   = 7'b0010101;
    localparam logic [6:0] C_EC_RW = 7'b0010010;
    localparam logic [6:0] C_EC    = 7'b0000010;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] instr;
    logic        mem_read, mem_write, reg_write;
    logic        mem_to_reg, link, ecall;
    logic [31:0] rdata1, rdata2, a_q, b_q, pc;
    logic [31:0] alu_result, jump_target;
    logic        jump_flag;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] io_data;
    logic        io_finish;
    logic        ecall_busy;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    mc_datapath_seq dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_valid (dmem_valid),
        .dmem_rdata (dmem_rdata),
        .instr      (instr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .link       (link),
        .ecall      (ecall),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .a_q        (a_q),
        .b_q        (b_q),
        .pc         (pc),
        .alu_result (alu_result),
        .jump_target(jump_target),
        .jump_flag  (jump_flag),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .io_data    (io_data),
        .io_finish  (io_finish),
        .ecall_busy (ecall_busy),
        .state      (state),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    int  imem_wait = 0;
    int  dmem_wait = 0;
    int  ecall_hold = 0;
    bit  io_force = 0;
    bit  dmem_force = 0;
    int  icnt = 0, dcnt = 0, ecnt = 0;

    int          busy_n = 0;
    int          dreq_n = 0;
    int          jitter = 0;
    logic        prev_req = 0;
    logic [13:0] prev_addr = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] a, input logic [31:0] b, input string nm);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind %0d a=%h b=%h", nm, kind, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                errors++;
                $display("FAIL %s: got kind %0d a=%h b=%h expected kind %0d a=%h b=%h", nm, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic exp_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    // memory and io responders, driven on the falling edge
    always @(negedge clk) begin
        if (imem_req) begin
            imem_valid = (icnt >= imem_wait);
            icnt++;
        end else begin
            imem_valid = 1'b0;
            icnt = 0;
        end
        if (dmem_req) begin
            dmem_valid = (dcnt >= dmem_wait) || dmem_force;
            dcnt++;
        end else begin
            dmem_valid = dmem_force;
            dcnt = 0;
        end
        if (ecall_busy) begin
            io_finish = io_force || (ecnt >= ecall_hold);
            ecnt++;
        end else begin
            io_finish = io_force;
            ecnt = 0;
        end
    end

    // monitor: compare every DUT-presented event against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (imem_req && imem_valid)
                    pop_cmp(0, imem_addr, 32'h0, "fetch");
                if (dmem_req && dmem_valid)
                    pop_cmp(dmem_we ? 3 : 2, {18'b0, dmem_addr}, dmem_wdata, "dmem");
                if (rf_we)
                    pop_cmp(1, rf_wdata, 32'h0, "rf_write");
                if (ecall_busy)
                    busy_n++;
                if (dmem_req) begin
                    dreq_n++;
                    if (prev_req && dmem_addr != prev_addr)
                        jitter++;
                end
                prev_req = dmem_req;
                prev_addr = dmem_addr;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    task automatic cfg(input logic [31:0] ir, input logic [6:0] c, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] alu, input logic [31:0] jt);
        imem_rdata = ir;
        {mem_read, mem_write, reg_write, mem_to_reg, link, ecall, jump_flag} = c;
        rdata1 = r1;
        rdata2 = r2;
        alu_result = alu;
        jump_target = jt;
    endtask

    // run one instruction from its FETCH until the next FETCH
    task automatic run(input int exp_cyc, input string nm);
        int cyc;
        bit left;
        cyc = 0;
        left = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (state != 3'd0)
                left = 1;
            else if (left)
                break;
        end
        chk(nm, cyc, exp_cyc);
    endtask

    int b0, d0, n;

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        io_finish = 1'b0;
        io_data = 32'h0;
        dmem_rdata = 32'h0;
        cfg(32'h0, C_NONE, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst state", {29'b0, state}, 0);
        chk("rst pc", pc, 0);
        chk("rst instr", instr, 32'h0000_0013);
        chk("rst a_q", a_q, 0);
        chk("rst b_q", b_q, 0);
        chk("rst retire_cnt", retire_cnt, 0);
        chk("rst imem_req", {31'b0, imem_req}, 0);
        chk("rst outs", {28'b0, dmem_req, rf_we, ecall_busy, 1'b0}, 0);

        // addi x1,x0,5
        cfg(32'h0050_0093, C_ALU, 0, 0, 5, 0);
        exp_ev(0, 32'h0, 0);
        exp_ev(1, 32'h5, 0);
        reset = 1'b0;
        #1;
        chk("imem_req after reset", {31'b0, imem_req}, 1);
        run(4, "addi cycles");
        chk("addi pc", pc, 32'h4);
        chk("addi instr", instr, 32'h0050_0093);

        // lw with three dmem wait cycles
        cfg(32'h0000_a103, C_LW, 32'h10, 32'h55, 32'h1234_5678, 0);
        dmem_rdata = 32'hDEAD_BEEF;
        dmem_wait = 3;
        exp_ev(0, 32'h4, 0);
        exp_ev(2, 32'h1678, 32'h55);
        exp_ev(1, 32'hDEAD_BEEF, 0);
        d0 = dreq_n;
        run(8, "lw cycles");
        chk("lw dmem_req cycles", dreq_n - d0, 4);
        chk("lw pc", pc, 32'h8);

        // sw with two imem wait cycles
        cfg(32'h0020_a023, C_SW, 32'h0, 32'hCAFE_F00D, 32'h100, 0);
        imem_wait = 2;
        dmem_wait = 0;
        exp_ev(0, 32'h8, 0);
        exp_ev(3, 32'h100, 32'hCAFE_F00D);
        run(6, "sw cycles");
        chk("sw pc", pc, 32'hC);
        imem_wait = 0;

        // taken beq to 0x40
        cfg(32'h0000_0063, C_BR, 0, 0, 0, 32'h40);
        exp_ev(0, 32'hC, 0);
        d0 = dreq_n;
        run(3, "beq cycles");
        chk("beq pc", pc, 32'h40);
        chk("beq no dmem", dreq_n - d0, 0);

        // jal at 0x40 to 0x10, then jal at 0x10 to 0x200
        cfg(32'h0000_00ef, C_JAL, 0, 0, 32'h999, 32'h10);
        exp_ev(0, 32'h40, 0);
        exp_ev(1, 32'h44, 0);
        run(4, "jal1 cycles");
        chk("jal1 pc", pc, 32'h10);
        cfg(32'h0000_00ef, C_JAL, 0, 0, 32'h999, 32'h200);
        exp_ev(0, 32'h10, 0);
        exp_ev(1, 32'h14, 0);
        run(4, "jal2 cycles");
        chk("jal2 pc", pc, 32'h200);

        // ecall with rd, io_finish low for ten cycles
        cfg(32'h0000_0073, C_EC_RW, 0, 0, 0, 0);
        io_data = 32'hA5;
        ecall_hold = 10;
        exp_ev(0, 32'h200, 0);
        exp_ev(1, 32'hA5, 0);
        b0 = busy_n;
        run(13, "ecall cycles");
        chk("ecall busy cycles", busy_n - b0, 11);
        chk("ecall pc", pc, 32'h204);

        // ecall without rd, io_finish already high
        cfg(32'h0000_0073, C_EC, 0, 0, 0, 0);
        io_force = 1;
        exp_ev(0, 32'h204, 0);
        b0 = busy_n;
        run(3, "ecall2 cycles");
        chk("ecall2 busy cycles", busy_n - b0, 1);
        chk("ecall2 pc", pc, 32'h208);
        io_force = 0;

        // op with no rd, no memory, no jump
        cfg(32'h0000_0013, C_NONE, 0, 0, 32'h77, 32'h500);
        exp_ev(0, 32'h208, 0);
        run(3, "nop cycles");
        chk("nop pc", pc, 32'h20C);

        // branch to the top of memory, then jal there wraps pc+4
        cfg(32'h0000_0063, C_BR, 0, 0, 0, 32'hFFFF_FFFC);
        exp_ev(0, 32'h20C, 0);
        run(3, "br hi cycles");
        cfg(32'h0000_00ef, C_JAL, 0, 0, 0, 32'h300);
        exp_ev(0, 32'hFFFF_FFFC, 0);
        exp_ev(1, 32'h0, 0);
        run(4, "jal wrap cycles");
        chk("jal wrap pc", pc, 32'h300);
`ifdef DP_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, 11);
`else
        chk("retire_cnt", retire_cnt, 0);
`endif

        // lw whose data never arrives, abandoned by reset
        cfg(32'h0000_a103, C_LW, 0, 0, 32'h80, 0);
        dmem_wait = 1000;
        exp_ev(0, 32'h300, 0);
        n = 0;
        while (!dmem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached MEM", {31'b0, dmem_req}, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("rst dmem_req", {31'b0, dmem_req}, 0);
        chk("rst strobes", {29'b0, imem_req, rf_we, ecall_busy}, 0);
        @(posedge clk);
        #1;
        chk("midrst state", {29'b0, state}, 0);
        chk("midrst pc", pc, 0);
        chk("midrst instr", instr, 32'h0000_0013);
        chk("midrst retire_cnt", retire_cnt, 0);

        // late dmem_valid during the next fetch must be ignored
        cfg(32'h0090_0093, C_ALU, 0, 0, 9, 0);
        imem_wait = 3;
        dmem_force = 1;
        exp_ev(0, 32'h0, 0);
        exp_ev(1, 32'h9, 0);
        reset = 1'b0;
        run(7, "post-reset addi cycles");
        dmem_force = 0;
        chk("post-reset pc", pc, 32'h4);
`ifdef DP_RETIRE_CNT_EN
        chk("post-reset retire_cnt", retire_cnt, 1);
`else
        chk("post-reset retire_cnt", retire_cnt, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("dmem_addr stable", jitter, 0);
        chk("scoreboard empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
